// File: rtl/dcs_reg_capture_if.sv
// Decoded DSI byte stream into the register-capture block, and the committed
// register/S-wire results out of it.
interface dcs_reg_capture_if;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        i_byte_sop;
  logic        i_byte_eop;
  logic [15:0] o_b1_data;
  logic [15:0] o_b5_data;
  logic        o_swire_start;
  logic        o_upd;
  logic        o_drop;

  modport master (
    output i_byte_valid, i_byte, i_byte_sop, i_byte_eop,
    input  o_b1_data, o_b5_data, o_swire_start, o_upd, o_drop
  );

  modport slave (
    input  i_byte_valid, i_byte, i_byte_sop, i_byte_eop,
    output o_b1_data, o_b5_data, o_swire_start, o_upd, o_drop
  );
endinterface

// File: rtl/dcs_reg_capture.sv
// DSI packet parser: captures B1h/B5h long-write parameters and display on/off
// state, committing outputs only when a packet completes cleanly.
module dcs_reg_capture #(
  parameter logic [7:0]  B1_ADDR = 8'hB1,
  parameter logic [7:0]  B5_ADDR = 8'hB5,
  parameter logic [15:0] B1_RST  = 16'h0000,
  parameter logic [15:0] B5_RST  = 16'h0000,
  parameter logic [15:0] TIMEOUT = 16'd4095
) (
  input logic              i_clk_38m,
  input logic              i_reset,
  dcs_reg_capture_if.slave bus
);

  localparam logic [7:0] DT_SHORT0 = 8'h05;
  localparam logic [7:0] DT_SHORT1 = 8'h15;
  localparam logic [7:0] DT_LONG   = 8'h39;

  typedef enum logic [2:0] {S_IDLE, S_WC_LO, S_WC_HI, S_CMD, S_PARAM, S_SKIP} state_e;

  state_e      state_q, state_d;
  logic [7:0]  dt_q, dt_d, cmd_q, cmd_d;
  logic        cmd_vld_q, cmd_vld_d;
  logic [15:0] wc_q, wc_d, pc_q, pc_d, sh_q, sh_d, idle_q, idle_d;
  logic [15:0] b1_q, b1_d, b5_q, b5_d;
  logic        sw_q, sw_d, upd_q, upd_d, drop_q, drop_d;

  logic        vld, sop, eop, tmo, tracked_q, commit;
  logic [7:0]  byte_in;
  logic [15:0] idle_inc;

  assign vld      = bus.i_byte_valid;
  assign sop      = bus.i_byte_sop;
  assign eop      = bus.i_byte_eop;
  assign byte_in  = bus.i_byte;
  assign idle_inc = idle_q + 16'd1;
  assign tmo      = !vld && (state_q != S_IDLE) && (idle_inc == TIMEOUT);

  function automatic logic is_reg(input logic [7:0] c);
    return (c == B1_ADDR) || (c == B5_ADDR);
  endfunction

  // A packet "matters" for o_drop only once a long write has named B1h/B5h.
  assign tracked_q = (dt_q == DT_LONG) && cmd_vld_q && is_reg(cmd_q);

  always_ff @(posedge i_clk_38m or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (vld && sop) begin
      case (byte_in)
        DT_SHORT0, DT_SHORT1: state_d = S_CMD;
        DT_LONG:              state_d = S_WC_LO;
        default:              state_d = S_SKIP;
      endcase
      if (eop) state_d = S_IDLE;
    end else if (vld) begin
      case (state_q)
        S_WC_LO: state_d = S_WC_HI;
        S_WC_HI: state_d = S_CMD;
        S_CMD:   state_d = S_PARAM;
        default: state_d = state_q;
      endcase
      if (eop) state_d = S_IDLE;
    end else if (tmo) begin
      state_d = S_IDLE;
    end
  end

  always_comb begin
    dt_d      = dt_q;
    cmd_d     = cmd_q;
    cmd_vld_d = cmd_vld_q;
    wc_d      = wc_q;
    pc_d      = pc_q;
    sh_d      = sh_q;
    idle_d    = idle_q;
    b1_d      = b1_q;
    b5_d      = b5_q;
    sw_d      = sw_q;
    upd_d     = 1'b0;
    drop_d    = 1'b0;
    commit    = 1'b0;
    if (vld) begin
      idle_d = '0;
      if (sop) begin
        // A sop mid-packet aborts the old packet and starts the new one at once.
        drop_d    = (state_q != S_IDLE) && tracked_q;
        dt_d      = byte_in;
        cmd_vld_d = 1'b0;
        wc_d      = '0;
        pc_d      = '0;
        sh_d      = '0;
      end else begin
        case (state_q)
          S_WC_LO: wc_d[7:0] = byte_in;
          S_WC_HI: begin
            wc_d[15:8] = byte_in;
            pc_d       = '0;
          end
          S_CMD: begin
            cmd_d     = byte_in;
            cmd_vld_d = 1'b1;
            pc_d      = 16'd1;
          end
          S_PARAM: begin
            pc_d = (pc_q == 16'hFFFF) ? pc_q : pc_q + 16'd1;
            if (dt_q == DT_LONG) begin
              if (pc_q == 16'd1)      sh_d[15:8] = byte_in;
              else if (pc_q == 16'd2) sh_d[7:0]  = byte_in;
            end
          end
          default: ;
        endcase
        commit = eop && (state_q != S_IDLE);
      end
    end else if (state_q != S_IDLE) begin
      idle_d = tmo ? 16'd0 : idle_inc;
      drop_d = tmo && tracked_q;
    end

    // Commit looks at the post-byte view so an eop on CMD or P2 counts that byte.
    if (commit) begin
      if ((dt_q == DT_LONG) && cmd_vld_d && is_reg(cmd_d)) begin
        if ((pc_d == wc_d) && (wc_d >= 16'd3)) begin
          if (cmd_d == B1_ADDR) b1_d = sh_d;
          if (cmd_d == B5_ADDR) b5_d = sh_d;
          upd_d = 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end else if ((dt_q == DT_SHORT0) && cmd_vld_d) begin
        case (cmd_d)
          8'h29:        sw_d = 1'b1;
          8'h28, 8'h10: sw_d = 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk_38m or posedge i_reset) begin
    if (i_reset) begin
      dt_q      <= '0;
      cmd_q     <= '0;
      cmd_vld_q <= 1'b0;
      wc_q      <= '0;
      pc_q      <= '0;
      sh_q      <= '0;
      idle_q    <= '0;
      b1_q      <= B1_RST;
      b5_q      <= B5_RST;
      sw_q      <= 1'b0;
      upd_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      dt_q      <= dt_d;
      cmd_q     <= cmd_d;
      cmd_vld_q <= cmd_vld_d;
      wc_q      <= wc_d;
      pc_q      <= pc_d;
      sh_q      <= sh_d;
      idle_q    <= idle_d;
      b1_q      <= b1_d;
      b5_q      <= b5_d;
      sw_q      <= sw_d;
      upd_q     <= upd_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.o_b1_data     = b1_q;
  assign bus.o_b5_data     = b5_q;
  assign bus.o_swire_start = sw_q;
  assign bus.o_upd         = upd_q;
  assign bus.o_drop        = drop_q;

endmodule

// File: tb/tb_dcs_reg_capture.sv
// Scoreboard bench for dcs_reg_capture: expected output vectors
// {b1, b5, swire, upd, drop} are queued as packets are driven.
module tb_dcs_reg_capture;
  localparam logic [15:0] TMO = 16'd4095;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #13 clk = ~clk;

  dcs_reg_capture_if bus ();

  dcs_reg_capture #(.TIMEOUT(TMO)) dut (
    .i_clk_38m (clk),
    .i_reset   (rst),
    .bus       (bus)
  );

  logic [34:0] sb[$];
  logic [34:0] exp_v;
  logic [15:0] m_b1, m_b5;
  logic        m_sw;
  int          n_vec = 0;
  int          n_miss = 0;

  function automatic logic [34:0] obs();
    return {bus.o_b1_data, bus.o_b5_data, bus.o_swire_start, bus.o_upd, bus.o_drop};
  endfunction

  function automatic logic [34:0] mk(input logic upd, input logic drop);
    return {m_b1, m_b5, m_sw, upd, drop};
  endfunction

  task automatic put(input logic [7:0] b, input logic s, input logic e);
    @(negedge clk);
    bus.i_byte_valid = 1'b1;
    bus.i_byte       = b;
    bus.i_byte_sop   = s;
    bus.i_byte_eop   = e;
    @(posedge clk);
    #1;
    bus.i_byte_valid = 1'b0;
    bus.i_byte_sop   = 1'b0;
    bus.i_byte_eop   = 1'b0;
  endtask

  // Bytes are packed MSB-first; first gets sop, last gets eop.
  task automatic send(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++)
      put(v[8*(n-1-i) +: 8], i == 0, i == n - 1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    m_b1 = 16'h0000; m_b5 = 16'h0000; m_sw = 1'b0;
    sb.push_back(mk(1'b0, 1'b0));
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL reset: got %h exp %h", obs(), exp_v); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_b1_write();
    m_b1 = 16'h0290;
    sb.push_back(mk(1'b1, 1'b0));
    send(64'h39_03_00_B1_02_90, 6);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL b1_commit: got %h exp %h", obs(), exp_v); end
    @(posedge clk); #1;
    sb.push_back(mk(1'b0, 1'b0));
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL upd_width: got %h exp %h", obs(), exp_v); end
  endtask

  task automatic test_b5_swire();
    m_b5 = 16'hDC0A;
    sb.push_back(mk(1'b1, 1'b0));
    send(64'h39_03_00_B5_DC_0A, 6);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL b5_commit: got %h exp %h", obs(), exp_v); end
    m_sw = 1'b1;
    sb.push_back(mk(1'b0, 1'b0));
    send(64'h05_29_00, 3);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL disp_on: got %h exp %h", obs(), exp_v); end
    m_sw = 1'b0;
    sb.push_back(mk(1'b0, 1'b0));
    send(64'h05_28_00, 3);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL disp_off: got %h exp %h", obs(), exp_v); end
  endtask

  task automatic test_short_param();
    sb.push_back(mk(1'b0, 1'b1));
    send(64'h39_03_00_B1_55, 5);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL short_drop: got %h exp %h", obs(), exp_v); end
    @(posedge clk); #1;
    sb.push_back(mk(1'b0, 1'b0));
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL drop_width: got %h exp %h", obs(), exp_v); end
  endtask

  task automatic test_abort();
    put(8'h39, 1'b1, 1'b0); put(8'h03, 1'b0, 1'b0); put(8'h00, 1'b0, 1'b0);
    put(8'hB1, 1'b0, 1'b0); put(8'h08, 1'b0, 1'b0);
    sb.push_back(mk(1'b0, 1'b1));
    put(8'h39, 1'b1, 1'b0);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL abort_drop: got %h exp %h", obs(), exp_v); end
    m_b5 = 16'h1122;
    sb.push_back(mk(1'b1, 1'b0));
    put(8'h03, 1'b0, 1'b0); put(8'h00, 1'b0, 1'b0); put(8'hB5, 1'b0, 1'b0);
    put(8'h11, 1'b0, 1'b0); put(8'h22, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL abort_next: got %h exp %h", obs(), exp_v); end
  endtask

  task automatic test_boundaries();
    sb.push_back(mk(1'b0, 1'b1));
    send(64'h39_02_00_B1_01, 5);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL wc2_drop: got %h exp %h", obs(), exp_v); end
    m_b5 = 16'h0102;
    sb.push_back(mk(1'b1, 1'b0));
    send(64'h39_04_00_B5_01_02_03, 7);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL wc4_commit: got %h exp %h", obs(), exp_v); end
    sb.push_back(mk(1'b0, 1'b1));
    send(64'h39_03_00_B5_07_08_09, 7);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL overrun_drop: got %h exp %h", obs(), exp_v); end
    sb.push_back(mk(1'b0, 1'b0));
    send(64'h15_B1_33_00, 4);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL dt15_quiet: got %h exp %h", obs(), exp_v); end
    m_sw = 1'b1;
    sb.push_back(mk(1'b0, 1'b0));
    send(64'h05_29_00, 3);
    send(64'h05_11_00, 3);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL sleep_out_noop: got %h exp %h", obs(), exp_v); end
    m_sw = 1'b0;
    sb.push_back(mk(1'b0, 1'b0));
    send(64'h05_10, 2);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL sleep_in_len2: got %h exp %h", obs(), exp_v); end
    sb.push_back(mk(1'b0, 1'b0));
    send(64'h0A_B1_01_02, 4);
    put(8'h39, 1'b1, 1'b1);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL skip_single: got %h exp %h", obs(), exp_v); end
  endtask

  task automatic test_timeout();
    int  hit = 0;
    put(8'h39, 1'b1, 1'b0); put(8'h03, 1'b0, 1'b0); put(8'h00, 1'b0, 1'b0);
    put(8'hB1, 1'b0, 1'b0); put(8'h77, 1'b0, 1'b0);
    for (int k = 1; k <= int'(TMO) + 10; k++) begin
      @(posedge clk); #1;
      if (bus.o_drop === 1'b1) begin hit = k; break; end
    end
    n_vec++;
    if (hit !== int'(TMO)) begin n_miss++; $display("FAIL timeout_cycle: got %0d exp %0d", hit, TMO); end
    sb.push_back(mk(1'b0, 1'b0));
    put(8'h66, 1'b0, 1'b0);
    put(8'h66, 1'b0, 1'b1);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL timeout_late_p2: got %h exp %h", obs(), exp_v); end
  endtask

  task automatic test_reset_mid();
    m_b1 = 16'h0880;
    sb.push_back(mk(1'b1, 1'b0));
    send(64'h39_03_00_B1_08_80, 6);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL pre_reset_commit: got %h exp %h", obs(), exp_v); end
    send(64'h05_29_00, 3);
    put(8'h39, 1'b1, 1'b0); put(8'h03, 1'b0, 1'b0); put(8'h00, 1'b0, 1'b0);
    put(8'hB1, 1'b0, 1'b0); put(8'h12, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    m_b1 = 16'h0000; m_b5 = 16'h0000; m_sw = 1'b0;
    sb.push_back(mk(1'b0, 1'b0));
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL async_reset: got %h exp %h", obs(), exp_v); end
    @(negedge clk);
    rst = 1'b0;
    m_b1 = 16'hABCD;
    sb.push_back(mk(1'b1, 1'b0));
    send(64'h39_03_00_B1_AB_CD, 6);
    exp_v = sb.pop_front(); n_vec++;
    if (obs() !== exp_v) begin n_miss++; $display("FAIL post_reset_commit: got %h exp %h", obs(), exp_v); end
  endtask

  initial begin
    bus.i_byte_valid = 1'b0;
    bus.i_byte       = 8'h00;
    bus.i_byte_sop   = 1'b0;
    bus.i_byte_eop   = 1'b0;
    test_reset();
    test_b1_write();
    test_b5_swire();
    test_short_param();
    test_abort();
    test_boundaries();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/dcs_reg_capture.md
Name: dcs_reg_capture

Overview:
- Upstream neighbour of the S-wire LED driver in the MIPI command-mode path.
- Parses the decoded DSI packet byte stream from the MIPI receiver and captures the 16-bit parameters of panel registers B1h and B5h.
- Tracks display-on/off and sleep state and drives the S-wire start level.
- All outputs change only on a fully validated packet (atomic commit), so the LED driver never sees half-written data.

Parameters:
- B1_ADDR, 8'hB1, DCS command byte captured into o_b1_data
- B5_ADDR, 8'hB5, DCS command byte captured into o_b5_data
- B1_RST, 16'h0000, reset value of o_b1_data
- B5_RST, 16'h0000, reset value of o_b5_data
- TIMEOUT, 16'd4095, idle cycles inside a packet before it is aborted

Ports:
- i_clk_38m  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_byte_valid  in  1  i_byte is valid this cycle; no back-pressure, every valid byte is consumed
- i_byte  in  8  packet byte
- i_byte_sop  in  1  qualifies first byte of a packet (data type)
- i_byte_eop  in  1  qualifies last byte of a packet; may coincide with sop
- o_b1_data  out  16  last committed B1h parameter pair, {P1,P2}
- o_b5_data  out  16  last committed B5h parameter pair, {P1,P2}
- o_swire_start  out  1  display active level for the S-wire driver
- o_upd  out  1  one-cycle pulse when o_b1_data or o_b5_data is committed
- o_drop  out  1  one-cycle pulse when a B1h/B5h packet is discarded

Behaviour:
- Reset values: o_b1_data=B1_RST, o_b5_data=B5_RST, o_swire_start=0, o_upd=0, o_drop=0, FSM=IDLE, all shadow registers and counters cleared. Reset mid-packet discards the packet with no commit.
- Byte framing: sop byte = data type (DT). Packet layouts:
  - DT 05h (short, no parameter): DT, CMD, ECC.
  - DT 15h (short, one parameter): DT, CMD, P, ECC.
  - DT 39h (long write): DT, WC_LO, WC_HI, CMD, P1..Pn. WC counts CMD plus parameters.
- FSM states: IDLE, WC_LO, WC_HI, CMD, PARAM, SKIP.
- IDLE:
  - Valid sop with DT 05h/15h goes to CMD.
  - DT 39h goes to WC_LO.
  - Any other DT goes to SKIP.
  - Valid byte without sop is ignored.
- WC_LO, WC_HI: latch wc[7:0], then wc[15:8]; go to CMD. Payload counter pc=0.
- CMD: latch cmd; pc=1; go to PARAM.
- PARAM:
  - Each valid byte increments pc (saturates at 16'hFFFF).
  - For DT 39h: byte at pc=1 goes to shadow[15:8], pc=2 goes to shadow[7:0]; later bytes are ignored.
  - For DT 05h/15h: bytes are ignored.
- SKIP: consume bytes until eop.
- A valid byte with eop returns the FSM to IDLE, and the commit is evaluated on that same edge:
  - DT 39h and cmd==B1_ADDR or B5_ADDR: commit only if received payload count (pc after this byte) equals wc and wc>=3. On commit, the matching output is updated from {shadow[15:8], shadow[7:0]} and o_upd=1. Otherwise nothing is written and o_drop=1.
  - If B1_ADDR==B5_ADDR, both outputs are written.
  - DT 05h, packet length>=2: cmd 29h sets o_swire_start=1; cmd 28h or 10h clears it; cmd 11h has no effect; others are ignored.
  - DT 15h: never writes registers; o_drop stays 0.
- Latency: outputs are visible the cycle after the eop byte is sampled. o_upd and o_drop are high for exactly that one cycle.
- sop while not IDLE: the in-flight packet is aborted, with o_drop=1 if its cmd was B1/B5. The sop byte is then processed as a new DT in the same cycle. sop together with eop: single-byte packet, no commit.
- Timeout: a 16-bit idle counter counts cycles with no valid byte while not IDLE, and clears on every valid byte. When it reaches TIMEOUT, the FSM returns to IDLE with o_drop=1 if cmd was B1/B5.
- o_b1_data and o_b5_data hold their values indefinitely between commits.

Test Plan:
- Long write 39h, 03h, 00h, B1h, 02h, 90h with eop on 90h -> o_b1_data=16'h0290 one cycle after eop, o_upd pulse of 1 cycle, o_b5_data unchanged.
- Long write 39h, 03h, 00h, B5h, DCh, 0Ah, then short 05h, 29h, 00h -> o_b5_data=16'hDC0A; o_swire_start rises one cycle after the second eop. Then 05h, 28h, 00h -> o_swire_start=0.
- Long write B1h with WC=3 but only one parameter (eop on P1) -> o_b1_data keeps its prior value, o_drop=1 for one cycle, o_upd=0.
- New sop arriving after B1h, 08h (before P2), followed by a complete B5h packet -> B1 not written, o_drop pulse, then B5 commits normally.
- B1h packet stalled TIMEOUT cycles after P1 -> FSM in IDLE, o_drop pulse; later P2 without sop is ignored and o_b1_data is unchanged.
- Assert i_reset mid-packet after a prior commit of 16'h0880 -> o_b1_data=B1_RST and o_swire_start=0 immediately; the next full packet commits normally.
